alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Command sequencer in front of the 16-bit button-driven ALU. Accepts {opcode, operand}
//  commands over valid/ready into a small FIFO. Drives the ALU one-hot buttons/busIn with
//  correct timing and returns {result, error, flags} per command over valid/ready.
//  Hides the ALU's 2-edge op pipeline and its forced no-op after each op from upstream masters.
// PARAMETERS
//  N          16  datapath width (ALU bus width)
//  DEPTH      4   command FIFO entries (power of 2, >=2)
//  CLR_ON_RST 1   1: issue an internal Clr (op 12) after reset before accepting commands
// PORTS
//  clk        in   1      single clock, all state on posedge
//  rst        in   1      asynchronous, active-high reset
//  cmd_valid  in   1      command offered
//  cmd_ready  out  1      command accepted when valid&ready at posedge
//  cmd_op     in   4      opcode: 1 +,2 -,3 x,4 &,5 |,6 ~,7 ^,8 ldA,9 ldB,10 Ans->A,11 Ans->B,12 Clr,13 A->Ans,14 B->Ans
//  cmd_data   in   N      operand for ldA/ldB (ignored otherwise)
//  rsp_valid  out  1      response held until rsp_ready
//  rsp_ready  in   1      response consumed when valid&ready at posedge
//  rsp_result out  N      ALU busOut after the op
//  rsp_error  out  3      {ovfl,udfl,trunc} sampled while the op is live
//  rsp_flags  out  4      {neg,A>B,A=B,A<B} after the op
//  rsp_illegal out 1      opcode 0 or 15; ALU untouched
//  alu_buttons out 14     one-hot ALU buttons; bit (op-1) for op
//  alu_bus_in out  N      ALU busIn
//  alu_bus_out in  N      ALU busOut
//  alu_error  in   3      ALU error
//  alu_flags  in   4      ALU flags
//  busy       out  1      state != IDLE or FIFO non-empty
// BEHAVIOUR
//  Reset values: outputs 0, FIFO empty, state WARM0. Reset mid-op aborts: FIFO and any
//   pending response are dropped, buttons return to 0 asynchronously.
//  Init sequence:
//   - WARM0 -> WARM1 with buttons=0 (lets the un-reset ALU opReg self-clear).
//   - Then, if CLR_ON_RST: ISSUE/EXEC/CAPT with op 12, no response generated.
//   - Then IDLE.
//   - cmd_ready = !fifo_full && init_done. Commands are never accepted during init.
//  IDLE: if FIFO non-empty, pop the head at the edge.
//   - Legal op -> ISSUE.
//   - Illegal op -> RESP with illegal=1 and result/error/flags = 0.
//  ISSUE (1 cyc): alu_buttons = 14'b1 << (op-1); alu_bus_in = operand.
//  EXEC (1 cyc): alu_buttons = 0; alu_bus_in held; rsp_error <= alu_error at the end of the cycle.
//  CAPT (1 cyc): buttons 0; rsp_result <= alu_bus_out, rsp_flags <= alu_flags at the end -> RESP.
//  RESP: rsp_valid=1, outputs stable; on rsp_ready -> IDLE.
//  Latency: FIFO-head pop to rsp_valid = 4 cycles. Throughput <= 1 op / 5 cycles.
//  Buttons are never non-zero on two consecutive cycles; exactly one bit is set in ISSUE only.
//  Simultaneous push and pop in IDLE is allowed when FIFO non-empty; count is unchanged.
//   Push when full is blocked by cmd_ready.
//  FIFO pointers wrap modulo DEPTH. Count is log2(DEPTH)+1 bits to tell full from empty.
//  alu_bus_in holds the last operand outside ISSUE/EXEC (no glitch to 0).
// STRUCTURE
//  Shared package alu_pkg:
//   - opcode localparams (OP_ADD=1 ... OP_BANS=14), ALU_BTN_W=14, ERR_W=3, FLAG_W=4
//   - state encoding {WARM0, WARM1, IDLE, ISSUE, EXEC, CAPT, RESP}
//  One sub-module: alu_cmd_fifo (sync FIFO, width 4+N, async active-high reset,
//   push/pop/full/empty/head).
// TESTING
//  - ldA 5, ldB 3, op 1 -> result 0x0008, error 0, flags 4'b0100; ALU buttons pulsed 1 cycle each.
//  - ldA 3, ldB 5, op 2 -> result 0xFFFE, flags 4'b1001; then op 10 (Ans->A) -> A=0xFFFE, flags[2]=1.
//  - ldA 0x7FFF, ldB 0x0002, op 1 -> result 0x8001, error 3'b100.
//  - Push 5 commands with rsp_ready=0, DEPTH=4 -> cmd_ready low after 4 (+1 in flight); no loss,
//    responses in order.
//  - op 0 and op 15 -> rsp_illegal=1, alu_buttons stay 0 throughout.
//  - rst pulsed during EXEC -> outputs 0 immediately; 2 warm cycles + Clr; next ldA 7, op 13 -> result 7.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the button-driven ALU command sequencer.
package alu_pkg;

  localparam int OP_W      = 4;
  localparam int ALU_BTN_W = 14;
  localparam int ERR_W     = 3;
  localparam int FLAG_W    = 4;

  localparam logic [OP_W-1:0] OP_NOP   = 4'd0;
  localparam logic [OP_W-1:0] OP_ADD   = 4'd1;
  localparam logic [OP_W-1:0] OP_SUB   = 4'd2;
  localparam logic [OP_W-1:0] OP_MUL   = 4'd3;
  localparam logic [OP_W-1:0] OP_AND   = 4'd4;
  localparam logic [OP_W-1:0] OP_OR    = 4'd5;
  localparam logic [OP_W-1:0] OP_NOT   = 4'd6;
  localparam logic [OP_W-1:0] OP_XOR   = 4'd7;
  localparam logic [OP_W-1:0] OP_LDA   = 4'd8;
  localparam logic [OP_W-1:0] OP_LDB   = 4'd9;
  localparam logic [OP_W-1:0] OP_ANS_A = 4'd10;
  localparam logic [OP_W-1:0] OP_ANS_B = 4'd11;
  localparam logic [OP_W-1:0] OP_CLR   = 4'd12;
  localparam logic [OP_W-1:0] OP_AANS  = 4'd13;
  localparam logic [OP_W-1:0] OP_BANS  = 4'd14;
  localparam logic [OP_W-1:0] OP_BAD   = 4'd15;

  typedef enum logic [2:0] {
    ST_WARM0,
    ST_WARM1,
    ST_IDLE,
    ST_ISSUE,
    ST_EXEC,
    ST_CAPT,
    ST_RESP
  } state_t;

  // Opcodes 0 and 15 have no ALU button and never reach the ALU.
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return (op != OP_NOP) && (op != OP_BAD);
  endfunction

  // One-hot button vector for an opcode: bit (op-1); zero for illegal opcodes.
  function automatic logic [ALU_BTN_W-1:0] op_button(input logic [OP_W-1:0] op);
    logic [ALU_BTN_W-1:0] b;
    b = '0;
    if (op_legal(op)) b = ALU_BTN_W'(1) << (op - 4'd1);
    return b;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; DEPTH must be a power of two so pointers wrap naturally.
module alu_cmd_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; the extra count bit separates full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequencer that feeds queued {opcode, operand} commands to the button-driven ALU,
// hiding its two-edge op pipeline and post-op no-op, and returns one response per command.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int N          = 16,
  parameter int DEPTH      = 4,
  parameter bit CLR_ON_RST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [OP_W-1:0]      cmd_op,
  input  logic [N-1:0]         cmd_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [N-1:0]         rsp_result,
  output logic [ERR_W-1:0]     rsp_error,
  output logic [FLAG_W-1:0]    rsp_flags,
  output logic                 rsp_illegal,
  output logic [ALU_BTN_W-1:0] alu_buttons,
  output logic [N-1:0]         alu_bus_in,
  input  logic [N-1:0]         alu_bus_out,
  input  logic [ERR_W-1:0]     alu_error,
  input  logic [FLAG_W-1:0]    alu_flags,
  output logic                 busy
);

  localparam int CW = OP_W + N;

  state_t         state;
  state_t         state_nxt;
  logic           fifo_push;
  logic           fifo_pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_head;
  logic [OP_W-1:0] head_op;
  logic [N-1:0]   head_data;
  logic [OP_W-1:0] cur_op;
  logic           init_done;
  logic           init_clr;

  assign head_op   = fifo_head[CW-1 -: OP_W];
  assign head_data = fifo_head[N-1:0];
  assign cmd_ready = !fifo_full && init_done;
  assign fifo_push = cmd_valid && cmd_ready;
  assign busy      = (state != ST_IDLE) || !fifo_empty;

  alu_cmd_fifo #(
    .W     (CW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({cmd_op, cmd_data}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // State register; reset drops straight to WARM0 so the buttons clear at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_WARM0;
    else     state <= state_nxt;
  end

  // Next-state, FIFO pop and the decoded outputs that follow directly from state.
  always_comb begin
    state_nxt   = state;
    fifo_pop    = 1'b0;
    alu_buttons = '0;
    rsp_valid   = 1'b0;
    case (state)
      ST_WARM0: state_nxt = ST_WARM1;
      ST_WARM1: state_nxt = CLR_ON_RST ? ST_ISSUE : ST_IDLE;
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = op_legal(head_op) ? ST_ISSUE : ST_RESP;
        end
      end
      ST_ISSUE: begin
        alu_buttons = op_button(cur_op);
        state_nxt   = ST_EXEC;
      end
      ST_EXEC:  state_nxt = ST_CAPT;
      ST_CAPT:  state_nxt = init_clr ? ST_IDLE : ST_RESP;
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_WARM0;
    endcase
  end

  // Command latch, ALU operand and response capture at the points where the ALU output is valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_done   <= 1'b0;
      init_clr    <= 1'b0;
      cur_op      <= OP_NOP;
      alu_bus_in  <= '0;
      rsp_result  <= '0;
      rsp_error   <= '0;
      rsp_flags   <= '0;
      rsp_illegal <= 1'b0;
    end else begin
      if (state_nxt == ST_IDLE) init_done <= 1'b1;
      case (state)
        ST_WARM1: begin
          if (CLR_ON_RST) begin
            cur_op   <= OP_CLR;
            init_clr <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (!fifo_empty) begin
            cur_op      <= head_op;
            rsp_illegal <= !op_legal(head_op);
            rsp_result  <= '0;
            rsp_error   <= '0;
            rsp_flags   <= '0;
            if (op_legal(head_op)) alu_bus_in <= head_data;
          end
        end
        ST_EXEC: rsp_error <= alu_error;
        ST_CAPT: begin
          rsp_result <= alu_bus_out;
          rsp_flags  <= alu_flags;
          init_clr   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a cycle-level ALU peripheral model plus a transaction-level
// reference of expected responses, driven by directed and random command streams.
module tb_alu_op_sequencer;

  localparam int N     = 16;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = 4'd0;
  logic [N-1:0] cmd_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [N-1:0] rsp_result;
  logic [2:0]  rsp_error;
  logic [3:0]  rsp_flags;
  logic        rsp_illegal;
  logic [13:0] alu_buttons;
  logic [N-1:0] alu_bus_in;
  logic [N-1:0] alu_bus_out;
  logic [2:0]  alu_error;
  logic [3:0]  alu_flags;
  logic        busy;

  always #5 clk = ~clk;

  alu_op_sequencer #(.N(N), .DEPTH(DEPTH), .CLR_ON_RST(1'b1)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_error(rsp_error), .rsp_flags(rsp_flags), .rsp_illegal(rsp_illegal),
    .alu_buttons(alu_buttons), .alu_bus_in(alu_bus_in), .alu_bus_out(alu_bus_out),
    .alu_error(alu_error), .alu_flags(alu_flags), .busy(busy)
  );

  typedef struct packed { logic [15:0] a; logic [15:0] b; logic [15:0] ans; } regs_t;
  typedef struct packed { logic [15:0] res; logic [2:0] err; logic [3:0] flg; logic ill; } rsp_t;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ALU semantics: register effect of one op.
  function automatic regs_t alu_step(regs_t r, logic [3:0] op, logic [15:0] din);
    regs_t n;
    n = r;
    case (op)
      4'd1:  n.ans = r.a + r.b;
      4'd2:  n.ans = r.a - r.b;
      4'd3:  n.ans = r.a * r.b;
      4'd4:  n.ans = r.a & r.b;
      4'd5:  n.ans = r.a | r.b;
      4'd6:  n.ans = ~r.a;
      4'd7:  n.ans = r.a ^ r.b;
      4'd8:  n.a = din;
      4'd9:  n.b = din;
      4'd10: n.a = r.ans;
      4'd11: n.b = r.ans;
      4'd12: n = '0;
      4'd13: n.ans = r.a;
      4'd14: n.ans = r.b;
      default: ;
    endcase
    return n;
  endfunction

  // {ovfl, udfl, trunc} while an op is live.
  function automatic logic [2:0] alu_err(regs_t r, logic [3:0] op);
    logic [15:0] s;
    logic [15:0] d;
    logic [31:0] p;
    logic [2:0]  e;
    s = r.a + r.b;
    d = r.a - r.b;
    p = {16'd0, r.a} * {16'd0, r.b};
    e = 3'd0;
    if (op == 4'd1) e[2] = (r.a[15] == r.b[15]) && (s[15] != r.a[15]);
    if (op == 4'd2) e[1] = (r.a[15] != r.b[15]) && (d[15] != r.a[15]);
    if (op == 4'd3) e[0] = |p[31:16];
    return e;
  endfunction

  function automatic logic [3:0] alu_flg(regs_t r);
    return {r.ans[15], r.a > r.b, r.a == r.b, r.a < r.b};
  endfunction

  function automatic logic [3:0] btn_op(logic [13:0] b);
    logic [3:0] o;
    o = 4'd0;
    for (int i = 13; i >= 0; i--) if (b[i]) o = 4'(i + 1);
    return o;
  endfunction

  // ALU peripheral: not reset, latches a button press, executes it one edge later, then forces a no-op.
  regs_t      alu_r = {16'h1234, 16'hBEEF, 16'h5A5A};
  logic [3:0] alu_op_reg = 4'd9;
  always @(posedge clk) begin
    if (alu_op_reg != 4'd0) alu_r <= alu_step(alu_r, alu_op_reg, alu_bus_in);
    alu_op_reg <= (alu_op_reg != 4'd0) ? 4'd0 : btn_op(alu_buttons);
  end
  assign alu_bus_out = alu_r.ans;
  assign alu_error   = (alu_op_reg != 4'd0) ? alu_err(alu_r, alu_op_reg) : 3'd0;
  assign alu_flags   = alu_flg(alu_r);

  // Transaction-level reference: ALU state after each accepted command and queued expectations.
  regs_t ref_r = '0;
  rsp_t  exp_q[$];

  task automatic model_accept(input logic [3:0] op, input logic [15:0] data);
    rsp_t e;
    logic [2:0] er;
    if (op == 4'd0 || op == 4'd15) begin
      e = '{res: 16'd0, err: 3'd0, flg: 4'd0, ill: 1'b1};
    end else begin
      er = alu_err(ref_r, op);
      ref_r = alu_step(ref_r, op, data);
      e = '{res: ref_r.ans, err: er, flg: alu_flg(ref_r), ill: 1'b0};
    end
    exp_q.push_back(e);
  endtask

  // Response consumer ready pattern: 0 hold, 1 always, 2 random.
  int rdy_mode = 1;
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       rsp_ready = 1'b0;
      1:       rsp_ready = 1'b1;
      default: rsp_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: button pulse rules and in-order response comparison.
  int          btn_nz = 0;
  int          btn_viol = 0;
  int          n_rsp = 0;
  logic [13:0] prev_btn = '0;
  rsp_t        last = '0;
  rsp_t        mon_e;
  always @(negedge clk) begin
    if (rst) begin
      prev_btn = '0;
    end else begin
      if (alu_buttons != 14'd0) btn_nz++;
      if ($countones(alu_buttons) > 1 || (prev_btn != 14'd0 && alu_buttons != 14'd0)) btn_viol++;
      prev_btn = alu_buttons;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_result", 32'(rsp_result), 32'(mon_e.res));
          chk("rsp_error", 32'(rsp_error), 32'(mon_e.err));
          chk("rsp_flags", 32'(rsp_flags), 32'(mon_e.flg));
          chk("rsp_illegal", 32'(rsp_illegal), 32'(mon_e.ill));
          last = '{res: rsp_result, err: rsp_error, flg: rsp_flags, ill: rsp_illegal};
          n_rsp++;
        end
      end
    end
  end

  task automatic do_reset();
    int cnt;
    logic [13:0] clr_btn;
    rst = 1'b1;
    cmd_valid = 1'b0;
    exp_q.delete();
    ref_r = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cnt = 0;
    clr_btn = '0;
    while (!cmd_ready && cnt < 50) begin
      @(posedge clk);
      #1;
      cnt++;
      if (alu_buttons != 14'd0) clr_btn = alu_buttons;
    end
    chk("init_cycles", 32'(cnt), 32'd5);
    chk("init_clr_btn", 32'(clr_btn), 32'h0800);
  endtask

  task automatic send(input logic [3:0] op, input logic [15:0] data);
    int  n;
    logic ok;
    cmd_op = op;
    cmd_data = data;
    cmd_valid = 1'b1;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 300) begin
      @(negedge clk);
      ok = cmd_ready;
      if (!ok) begin
        @(posedge clk);
        #1;
      end
      n++;
    end
    if (!ok) begin
      chk("cmd_ready_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      model_accept(op, data);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_done", 32'(n < 2000), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    int r0;
    int n;
    logic [3:0] op;

    do_reset();

    // Add with no overflow.
    rdy_mode = 1;
    send(4'd8, 16'd5); send(4'd9, 16'd3); send(4'd1, 16'd0);
    drain();
    chk("add_res", 32'(last.res), 32'h0008);
    chk("add_err", 32'(last.err), 32'd0);
    chk("add_flags", 32'(last.flg), 32'b0100);

    // Subtract to negative, then move Ans into A.
    send(4'd8, 16'd3); send(4'd9, 16'd5); send(4'd2, 16'd0);
    drain();
    chk("sub_res", 32'(last.res), 32'hFFFE);
    chk("sub_flags", 32'(last.flg), 32'b1001);
    send(4'd10, 16'd0);
    drain();
    chk("ansa_agtb", 32'(last.flg[2]), 32'd1);
    send(4'd13, 16'd0);
    drain();
    chk("ansa_a", 32'(last.res), 32'hFFFE);

    // Signed overflow on add.
    send(4'd8, 16'h7FFF); send(4'd9, 16'h0002); send(4'd1, 16'd0);
    drain();
    chk("ovf_res", 32'(last.res), 32'h8001);
    chk("ovf_err", 32'(last.err), 32'b100);

    // Back-pressure: five commands fit (one in flight plus four queued).
    rdy_mode = 0;
    r0 = n_rsp;
    send(4'd8, 16'h0011); send(4'd9, 16'h0022); send(4'd7, 16'd0);
    send(4'd3, 16'd0); send(4'd14, 16'd0);
    @(negedge clk);
    chk("full_ready", 32'(cmd_ready), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("full_hold", 32'(cmd_ready), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1 rdy_mode = 1;
    drain();
    chk("full_count", 32'(n_rsp - r0), 32'd5);

    // Illegal opcodes never press a button.
    b0 = btn_nz;
    send(4'd0, 16'h1111); send(4'd15, 16'h2222);
    drain();
    chk("illegal_btn", 32'(btn_nz - b0), 32'd0);
    chk("illegal_flag", 32'(last.ill), 32'd1);

    // Reset while an op is in EXEC.
    send(4'd9, 16'h4321);
    drain();
    send(4'd8, 16'hAAAA);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (alu_buttons == 14'd0 && n < 50);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_btn", 32'(alu_buttons), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk("rst_busin", 32'(alu_bus_in), 32'd0);
    chk("rst_result", 32'(rsp_result), 32'd0);
    do_reset();
    send(4'd14, 16'd0);
    drain();
    chk("clr_b", 32'(last.res), 32'd0);
    send(4'd8, 16'd7); send(4'd13, 16'd0);
    drain();
    chk("rst_lda", 32'(last.res), 32'd7);

    // Random traffic with random response back-pressure.
    rdy_mode = 2;
    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) op = 4'($urandom_range(8, 9));
      send(op, 16'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1 rdy_mode = 1;
    drain();

    chk("btn_rule", 32'(btn_viol), 32'd0);
    chk("q_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
